// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states and the parity helper
// used by both the receiver and the transmitter.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } rx_state_t;

  // Parity bit a transmitter puts on the line; zero-padding the data does not change it.
  function automatic logic parity_of(input logic [31:0] data, input logic [1:0] mode);
    logic p;
    p = ^data;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser plus 3-sample majority vote around the middle of a bit period.
// The vote is valid on the tick at position OVERSAMPLE/2+1, using the live synchronised line.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter  int OVERSAMPLE = 16,
  localparam int TW         = $clog2(OVERSAMPLE)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_tick,
  input  logic [TW-1:0] i_pos,
  input  logic          i_rx,
  output logic          line_sync,
  output logic          bit_vote
);

  localparam logic [TW-1:0] POS_A = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] POS_B = TW'(OVERSAMPLE / 2);

  logic r_sync1;
  logic r_sync2;
  logic r_s0;
  logic r_s1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= LINE_IDLE;
      r_sync2 <= LINE_IDLE;
      r_s0    <= LINE_IDLE;
      r_s1    <= LINE_IDLE;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      if (i_tick && (i_pos == POS_A)) r_s0 <= r_sync2;
      if (i_tick && (i_pos == POS_B)) r_s1 <= r_sync2;
    end
  end

  assign line_sync = r_sync2;
  assign bit_vote  = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: tick-paced frame FSM, valid/ready output holding register,
// and one-cycle parity/framing/overrun pulses with their OR on Flag_Rx.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic                 CLK_Rx,
  input  logic                 RstRx,
  input  logic                 SampleTick,
  input  logic                 SerialInputData,
  input  logic                 ReadyRx,
  output logic [DATA_BITS-1:0] DataOut,
  output logic                 ValidRx,
  output logic                 ParityErr,
  output logic                 FrameErr,
  output logic                 OverrunErr,
  output logic                 Flag_Rx,
  output rx_state_t            o_dbg_state
);

  // Handshake: a word transfers in any cycle where ValidRx and ReadyRx are both 1;
  // DataOut is stable while ValidRx is 1 and ValidRx drops the cycle after the transfer
  // unless a new frame loads in that same cycle.

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;

  localparam logic [TW-1:0] TCNT_MAX  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] POS_DEC   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  rx_state_t r_state;
  rx_state_t w_state_nxt;

  logic [TW-1:0]        r_tcnt;
  logic [TW-1:0]        w_pos;
  logic [BW-1:0]        r_bcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_par_acc;
  logic                 r_par_err;
  logic                 r_stop_err;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_ovr;
  logic                 r_flag;

  logic w_line;
  logic w_vote;
  logic w_decide;
  logic w_ferr_now;
  logic w_frame_end;
  logic w_ferr_p;
  logic w_perr_p;
  logic w_good;
  logic w_ovr_p;
  logic w_load;

  // The detection tick in IDLE is position 0 of the start bit, so w_pos is the position of the current tick.
  assign w_pos = (r_tcnt == TCNT_MAX) ? '0 : r_tcnt + TW'(1);

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .i_clk     (CLK_Rx),
    .i_rst     (RstRx),
    .i_tick    (SampleTick),
    .i_pos     (w_pos),
    .i_rx      (SerialInputData),
    .line_sync (w_line),
    .bit_vote  (w_vote)
  );

  assign w_decide = SampleTick && (w_pos == POS_DEC) &&
                    ((r_state == START) || (r_state == DATA) ||
                     (r_state == PARITY) || (r_state == STOP));
  assign w_ferr_now = r_stop_err | ~w_vote;

  always_ff @(posedge CLK_Rx or posedge RstRx) begin
    if (RstRx) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:       if (SampleTick && !w_line) w_state_nxt = START;
      START:      if (w_decide) w_state_nxt = w_vote ? IDLE : DATA;
      DATA:       if (w_decide && (r_bcnt == LAST_DATA))
                    w_state_nxt = (PARITY_MODE == 0) ? STOP : PARITY;
      PARITY:     if (w_decide) w_state_nxt = STOP;
      STOP:       if (w_decide && (r_bcnt == LAST_STOP))
                    w_state_nxt = (w_ferr_now && !w_line) ? BREAK_WAIT : IDLE;
      BREAK_WAIT: if (SampleTick && w_line) w_state_nxt = IDLE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // Frame-end outcome, prioritised framing > parity > overrun > load.
  always_comb begin
    w_frame_end = (r_state == STOP) && w_decide && (r_bcnt == LAST_STOP);
    w_ferr_p    = w_frame_end && w_ferr_now;
    w_perr_p    = w_frame_end && !w_ferr_now && r_par_err;
    w_good      = w_frame_end && !w_ferr_now && !r_par_err;
    w_ovr_p     = w_good && r_valid && !ReadyRx;
    w_load      = w_good && !(r_valid && !ReadyRx);
  end

  always_ff @(posedge CLK_Rx or posedge RstRx) begin
    if (RstRx) begin
      r_tcnt     <= '0;
      r_bcnt     <= '0;
      r_shift    <= '0;
      r_par_acc  <= 1'b0;
      r_par_err  <= 1'b0;
      r_stop_err <= 1'b0;
    end else if (SampleTick) begin
      case (r_state)
        IDLE:       if (!w_line) r_tcnt <= '0;
        BREAK_WAIT: r_tcnt <= r_tcnt;
        default:    r_tcnt <= w_pos;
      endcase
      if (w_decide) begin
        case (r_state)
          START: begin
            r_bcnt     <= '0;
            r_par_acc  <= 1'b0;
            r_par_err  <= 1'b0;
            r_stop_err <= 1'b0;
          end
          DATA: begin
            r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
            r_par_acc <= r_par_acc ^ w_vote;
            r_bcnt    <= (r_bcnt == LAST_DATA) ? '0 : r_bcnt + BW'(1);
          end
          PARITY: r_par_err <= (w_vote != parity_of(32'(r_par_acc), 2'(PARITY_MODE)));
          STOP: begin
            r_stop_err <= r_stop_err | ~w_vote;
            r_bcnt     <= r_bcnt + BW'(1);
          end
          default: r_bcnt <= r_bcnt;
        endcase
      end
    end
  end

  always_ff @(posedge CLK_Rx or posedge RstRx) begin
    if (RstRx) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_flag  <= 1'b0;
    end else begin
      r_perr <= w_perr_p;
      r_ferr <= w_ferr_p;
      r_ovr  <= w_ovr_p;
      r_flag <= w_perr_p | w_ferr_p | w_ovr_p;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && ReadyRx) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign DataOut     = r_data;
  assign ValidRx     = r_valid;
  assign ParityErr   = r_perr;
  assign FrameErr    = r_ferr;
  assign OverrunErr  = r_ovr;
  assign Flag_Rx     = r_flag;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os (8 data bits, even parity, 1 stop, 16x oversample, tick every 4 clocks).
module tb_uart_rx_os;
  import uart_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int BIT      = TICK_DIV * 16;

  logic       CLK_Rx;
  logic       RstRx;
  logic       SampleTick;
  logic       SerialInputData;
  logic       ReadyRx;
  logic [7:0] DataOut;
  logic       ValidRx;
  logic       ParityErr;
  logic       FrameErr;
  logic       OverrunErr;
  logic       Flag_Rx;
  rx_state_t  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int tick_div = 0;

  logic [7:0] exp_q[$];
  int   n_valid_cyc, n_perr, n_ferr, n_ovr, n_flag, n_perr_flag, n_extra;
  logic seen_start;

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)) dut (
    .CLK_Rx          (CLK_Rx),
    .RstRx           (RstRx),
    .SampleTick      (SampleTick),
    .SerialInputData (SerialInputData),
    .ReadyRx         (ReadyRx),
    .DataOut         (DataOut),
    .ValidRx         (ValidRx),
    .ParityErr       (ParityErr),
    .FrameErr        (FrameErr),
    .OverrunErr      (OverrunErr),
    .Flag_Rx         (Flag_Rx),
    .o_dbg_state     (dbg_state)
  );

  // Clock and tick generation
  initial begin
    CLK_Rx = 1'b0;
    forever #5 CLK_Rx = ~CLK_Rx;
  end

  initial begin
    SampleTick = 1'b0;
    forever begin
      @(negedge CLK_Rx);
      tick_div   = (tick_div == TICK_DIV - 1) ? 0 : tick_div + 1;
      SampleTick = (tick_div == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor and scoreboard
  always @(negedge CLK_Rx) begin
    if (!RstRx) begin
      if (ValidRx) n_valid_cyc++;
      if (ParityErr) n_perr++;
      if (FrameErr) n_ferr++;
      if (OverrunErr) n_ovr++;
      if (Flag_Rx) n_flag++;
      if (ParityErr && Flag_Rx) n_perr_flag++;
      if (dbg_state == START) seen_start = 1'b1;
      if (ValidRx && ReadyRx) begin
        if (exp_q.size() == 0) n_extra++;
        else check("sb_word", 32'(DataOut), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic clear_counts();
    @(posedge CLK_Rx);
    #1;
    n_valid_cyc = 0;
    n_perr      = 0;
    n_ferr      = 0;
    n_ovr       = 0;
    n_flag      = 0;
    n_perr_flag = 0;
    seen_start  = 1'b0;
  endtask

  task automatic drive_bit(input logic b, input int cyc);
    SerialInputData = b;
    repeat (cyc) @(negedge CLK_Rx);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par_flip,
                            input logic stop_low, input int cpb);
    drive_bit(1'b0, cpb);
    for (int i = 0; i < 8; i++) drive_bit(data[i], cpb);
    drive_bit((^data) ^ par_flip, cpb);
    drive_bit(~stop_low, cpb);
  endtask

  task automatic set_ready(input logic r);
    @(posedge CLK_Rx);
    #1;
    ReadyRx = r;
  endtask

  initial begin
    RstRx           = 1'b1;
    SerialInputData = 1'b1;
    ReadyRx         = 1'b1;
    n_extra         = 0;
    repeat (4) @(negedge CLK_Rx);
    RstRx = 1'b0;
    @(negedge CLK_Rx);
    check("rst_valid", 32'(ValidRx), 32'd0);
    check("rst_data", 32'(DataOut), 32'h00);
    check("rst_flag", 32'(Flag_Rx), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    drive_bit(1'b1, 2 * BIT);

    // Good frame 0xA5, even parity bit 0
    clear_counts();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, BIT);
    drive_bit(1'b1, 2 * BIT);
    check("a5_valid_cycles", 32'(n_valid_cyc), 32'd1);
    check("a5_data", 32'(DataOut), 32'hA5);
    check("a5_perr", 32'(n_perr), 32'd0);
    check("a5_flag", 32'(n_flag), 32'd0);

    // Parity bit flipped
    clear_counts();
    send_frame(8'hA5, 1'b1, 1'b0, BIT);
    drive_bit(1'b1, 2 * BIT);
    check("par_perr", 32'(n_perr), 32'd1);
    check("par_flag", 32'(n_flag), 32'd1);
    check("par_together", 32'(n_perr_flag), 32'd1);
    check("par_valid", 32'(n_valid_cyc), 32'd0);

    // Stop bit low, then a 20-bit break
    clear_counts();
    send_frame(8'hFF, 1'b0, 1'b1, BIT);
    drive_bit(1'b0, 20 * BIT);
    check("brk_ferr", 32'(n_ferr), 32'd1);
    check("brk_flag", 32'(n_flag), 32'd1);
    check("brk_perr", 32'(n_perr), 32'd0);
    check("brk_valid", 32'(n_valid_cyc), 32'd0);
    check("brk_state", 32'(dbg_state), 32'(BREAK_WAIT));
    drive_bit(1'b1, 2 * BIT);
    check("brk_exit_state", 32'(dbg_state), 32'(IDLE));
    clear_counts();
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b0, BIT);
    drive_bit(1'b1, 2 * BIT);
    check("after_brk_data", 32'(DataOut), 32'h3C);
    check("after_brk_flag", 32'(n_flag), 32'd0);

    // Overrun with ReadyRx low
    set_ready(1'b0);
    clear_counts();
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b0, BIT);
    drive_bit(1'b1, 2 * BIT);
    check("ovr_first_valid", 32'(ValidRx), 32'd1);
    check("ovr_first_data", 32'(DataOut), 32'h11);
    send_frame(8'h22, 1'b0, 1'b0, BIT);
    drive_bit(1'b1, 2 * BIT);
    check("ovr_pulse", 32'(n_ovr), 32'd1);
    check("ovr_flag", 32'(n_flag), 32'd1);
    check("ovr_data_kept", 32'(DataOut), 32'h11);
    check("ovr_valid_held", 32'(ValidRx), 32'd1);
    set_ready(1'b1);
    @(negedge CLK_Rx);
    @(negedge CLK_Rx);
    check("ovr_valid_drop", 32'(ValidRx), 32'd0);

    // Low glitch of 4 ticks on an idle line
    clear_counts();
    drive_bit(1'b0, 4 * TICK_DIV);
    drive_bit(1'b1, 2 * BIT);
    check("glitch_seen_start", 32'(seen_start), 32'd1);
    check("glitch_state", 32'(dbg_state), 32'(IDLE));
    check("glitch_valid", 32'(n_valid_cyc), 32'd0);
    check("glitch_flag", 32'(n_flag), 32'd0);
    check("glitch_data", 32'(DataOut), 32'h11);

    // Line baud off by about -3% and +3%
    clear_counts();
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b0, 1'b0, BIT - 2);
    drive_bit(1'b1, 2 * BIT);
    exp_q.push_back(8'h69);
    send_frame(8'h69, 1'b0, 1'b0, BIT + 2);
    drive_bit(1'b1, 2 * BIT);
    check("baud_flag", 32'(n_flag), 32'd0);
    check("baud_valid_cycles", 32'(n_valid_cyc), 32'd2);

    // Reset during data bit 3 while a word is held
    set_ready(1'b0);
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b0, 1'b0, BIT);
    drive_bit(1'b1, 2 * BIT);
    check("hold_valid", 32'(ValidRx), 32'd1);
    check("hold_data", 32'(DataOut), 32'h77);
    drive_bit(1'b0, BIT);
    drive_bit(1'b0, BIT);
    drive_bit(1'b1, BIT);
    drive_bit(1'b0, BIT);
    drive_bit(1'b1, BIT / 2);
    #2;
    RstRx = 1'b1;
    #1;
    check("rst_mid_valid", 32'(ValidRx), 32'd0);
    check("rst_mid_data", 32'(DataOut), 32'h00);
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    exp_q.delete();
    SerialInputData = 1'b1;
    ReadyRx         = 1'b1;
    repeat (4) @(negedge CLK_Rx);
    RstRx = 1'b0;
    drive_bit(1'b1, 2 * BIT);
    clear_counts();
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, BIT);
    drive_bit(1'b1, 2 * BIT);
    check("post_rst_data", 32'(DataOut), 32'h5A);
    check("post_rst_flag", 32'(n_flag), 32'd0);

    check("sb_pending", 32'(exp_q.size()), 32'd0);
    check("sb_extra_words", 32'(n_extra), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
